// File: rtl/dispensador_pkg.sv
// Shared coin codes, unit values and controller state type for the change dispenser.
package dispensador_pkg;

  localparam logic [1:0] MON_2 = 2'b01;
  localparam logic [1:0] MON_3 = 2'b10;
  localparam logic [1:0] MON_4 = 2'b11;

  localparam logic [3:0] VAL_2 = 4'd2;
  localparam logic [3:0] VAL_3 = 4'd3;
  localparam logic [3:0] VAL_4 = 4'd4;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    REQ,
    REL,
    DONE,
    ERROR
  } estado_t;

  function automatic logic [3:0] valor_moneda(input logic [1:0] code);
    logic [3:0] v;
    case (code)
      MON_2:   v = VAL_2;
      MON_3:   v = VAL_3;
      MON_4:   v = VAL_4;
      default: v = '0;
    endcase
    return v;
  endfunction

  // A coin is usable only if it fits and does not strand a 1-unit remainder.
  function automatic logic elegible(input logic [3:0] pend, input logic [3:0] d);
    return (pend >= d) && ((pend - d) != 4'd1);
  endfunction

endpackage

// File: rtl/selector_moneda.sv
// Combinational coin choice: largest denomination in stock that keeps the remainder payable.
module selector_moneda
  import dispensador_pkg::*;
(
  input  logic [3:0] pendiente,
  input  logic       hay_2,
  input  logic       hay_3,
  input  logic       hay_4,
  output logic       found,
  output logic [1:0] code
);

  always_comb begin
    found = 1'b0;
    code  = MON_2;
    if (hay_4 && elegible(pendiente, VAL_4)) begin
      found = 1'b1;
      code  = MON_4;
    end else if (hay_3 && elegible(pendiente, VAL_3)) begin
      found = 1'b1;
      code  = MON_3;
    end else if (hay_2 && elegible(pendiente, VAL_2)) begin
      found = 1'b1;
      code  = MON_2;
    end
  end

endmodule

// File: rtl/dispensador_cambio.sv
// Change dispenser: pays a loaded amount coin by coin over a four-phase req/ack hopper
// handshake, tracking per-denomination stock and aborting when exact change is impossible.
module dispensador_cambio
  import dispensador_pkg::*;
#(
  parameter int unsigned STOCK_INIT = 7,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned ACK_TO     = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cambio,
  input  logic       cargar,
  input  logic       recarga,
  input  logic       moneda_ack,
  output logic       moneda_req,
  output logic [1:0] moneda_tipo,
  output logic       ocupado,
  output logic       listo,
  output logic       falta,
  output logic [3:0] pendiente
);

  localparam int unsigned TMR_W = (ACK_TO < 2) ? 1 : $clog2(ACK_TO + 1);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(ACK_TO - 1);
  localparam logic [STOCK_W-1:0] STOCK_LLENO = STOCK_W'(STOCK_INIT);

  estado_t            estado;
  logic [TMR_W-1:0]   timer;
  logic [STOCK_W-1:0] stock_2;
  logic [STOCK_W-1:0] stock_3;
  logic [STOCK_W-1:0] stock_4;
  logic               sel_found;
  logic [1:0]         sel_code;

  selector_moneda u_selector (
    .pendiente (pendiente),
    .hay_2     (stock_2 != '0),
    .hay_3     (stock_3 != '0),
    .hay_4     (stock_4 != '0),
    .found     (sel_found),
    .code      (sel_code)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado      <= IDLE;
      timer       <= '0;
      pendiente   <= '0;
      moneda_req  <= 1'b0;
      moneda_tipo <= '0;
      ocupado     <= 1'b0;
      listo       <= 1'b0;
      falta       <= 1'b0;
      stock_2     <= STOCK_LLENO;
      stock_3     <= STOCK_LLENO;
      stock_4     <= STOCK_LLENO;
    end else begin
      listo <= 1'b0;
      falta <= 1'b0;
      unique case (estado)
        IDLE: begin
          if (cargar) begin
            pendiente <= cambio;
            ocupado   <= 1'b1;
            estado    <= SELECT;
          end else if (recarga) begin
            stock_2 <= STOCK_LLENO;
            stock_3 <= STOCK_LLENO;
            stock_4 <= STOCK_LLENO;
          end
        end
        SELECT: begin
          if (pendiente == '0) begin
            listo  <= 1'b1;
            estado <= DONE;
          end else if (sel_found) begin
            moneda_tipo <= sel_code;
            timer       <= '0;
            moneda_req  <= 1'b1;
            estado      <= REQ;
          end else begin
            falta  <= 1'b1;
            estado <= ERROR;
          end
        end
        REQ: begin
          if (moneda_ack) begin
            timer      <= '0;
            moneda_req <= 1'b0;
            estado     <= REL;
          end else if (timer == TMR_LAST) begin
            moneda_req <= 1'b0;
            falta      <= 1'b1;
            estado     <= ERROR;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        REL: begin
          // The coin is counted only once the hopper has released ack.
          if (!moneda_ack) begin
            pendiente <= pendiente - valor_moneda(moneda_tipo);
            case (moneda_tipo)
              MON_2:   stock_2 <= stock_2 - STOCK_W'(1);
              MON_3:   stock_3 <= stock_3 - STOCK_W'(1);
              MON_4:   stock_4 <= stock_4 - STOCK_W'(1);
              default: ;
            endcase
            estado <= SELECT;
          end else if (timer == TMR_LAST) begin
            falta  <= 1'b1;
            estado <= ERROR;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        DONE, ERROR: begin
          ocupado <= 1'b0;
          estado  <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule
